// File: rtl/uart_rx_core_m.sv
// uart_rx_core_m -- oversampling UART receiver core.
//
// Turns an asynchronous serial line into parallel characters. It runs on an
// oversampling clock of baud x OVER_SAMPLING. The frame format is chosen at
// run time: 7 or 8 data bits, optional even/odd parity, and 1 or 2 stop bits.
// The format is captured when a start edge is seen and held for that frame.
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN - each bit is decided by a 2-of-3 vote over
//   centre-1, centre and centre+1. The vote is registered at centre+1, so the
//   accept strobe comes one cycle later than in the single-sample build.
//
// Ports:
//   CLK           in   oversampling clock
//   RST           in   asynchronous reset, active-high
//   iSEVEN_BIT    in   0 = 8 data bits, 1 = 7 data bits
//   iPARITY_EN    in   1 = a parity bit follows the data bits
//   iODD_PARITY   in   0 = even parity, 1 = odd parity
//   iSTOP_BIT     in   0 = 1 stop bit, 1 = 2 stop bits
//   iUART_RX      in   serial input, idle high, asynchronous to CLK
//   oRETRY        out  one-cycle pulse on a false start or a framing error
//   oPARITY_ERROR out  one-cycle pulse, coincident with oDE, on parity mismatch
//   oDE           out  one-cycle data-valid strobe
//   oDATA         out  last received character
//
// Output protocol: oDE is a plain strobe. There is no ready/backpressure.
// oDATA is valid from the cycle oDE is high until the next accepted frame.
// The consumer must take the character in the cycle oDE is high.
module uart_rx_core_m #(
    parameter int OVER_SAMPLING = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iSEVEN_BIT,
    input  logic                  iPARITY_EN,
    input  logic                  iODD_PARITY,
    input  logic                  iSTOP_BIT,
    input  logic                  iUART_RX,
    output logic                  oRETRY,
    output logic                  oPARITY_ERROR,
    output logic                  oDE,
    output logic [DATA_WIDTH-1:0] oDATA
);

    localparam int CW = $clog2(OVER_SAMPLING + 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif

    // The sample counter is cleared on the cycle after each decision.
    // The start bit is therefore decided half a bit after T0, and every later
    // bit is decided a full bit after the previous one.
    localparam logic [CW-1:0] START_AT = CW'(OVER_SAMPLING / 2 - 1 + VOTE_DLY);
    localparam logic [CW-1:0] BIT_AT   = CW'(OVER_SAMPLING - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic          rxs_d1;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_acc;
    logic          par_err;
    logic          cfg_seven;
    logic          cfg_par;
    logic          cfg_odd;
    logic          cfg_two;
    logic          bit_val;
    logic          sample_now;

    // Two-flop synchronizer, plus a history of the synchronized line.
    // The history is used for start-edge detection and, optionally, the vote.
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rxs_d2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d1  <= 1'b1;
            rxs_d2  <= 1'b1;
        end else begin
            rx_meta <= iUART_RX;
            rxs     <= rx_meta;
            rxs_d1  <= rxs;
            rxs_d2  <= rxs_d1;
        end
    end

    // The decision is taken at centre+1. At that point, rxs_d1 holds the
    // centre sample and rxs_d2 holds centre-1.
    assign bit_val = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d1  <= 1'b1;
        end else begin
            rx_meta <= iUART_RX;
            rxs     <= rx_meta;
            rxs_d1  <= rxs;
        end
    end

    assign bit_val = rxs;
`endif

    assign sample_now = (state == S_START) ? (cnt == START_AT) : (cnt == BIT_AT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_acc       <= 1'b0;
            par_err       <= 1'b0;
            cfg_seven     <= 1'b0;
            cfg_par       <= 1'b0;
            cfg_odd       <= 1'b0;
            cfg_two       <= 1'b0;
            oRETRY        <= 1'b0;
            oPARITY_ERROR <= 1'b0;
            oDE           <= 1'b0;
            oDATA         <= '0;
        end else begin
            oRETRY        <= 1'b0;
            oPARITY_ERROR <= 1'b0;
            oDE           <= 1'b0;
            cnt           <= cnt + CW'(1);

            case (state)
                S_IDLE: begin
                    if (rxs_d1 && !rxs) begin
                        state     <= S_START;
                        cnt       <= '0;
                        cfg_seven <= iSEVEN_BIT;
                        cfg_par   <= iPARITY_EN;
                        cfg_odd   <= iODD_PARITY;
                        cfg_two   <= iSTOP_BIT;
                    end
                end

                S_START: begin
                    if (sample_now) begin
                        cnt <= '0;
                        if (bit_val) begin
                            // The line went back high before mid-bit: treat it as a glitch.
                            oRETRY <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                            shreg   <= '0;
                            par_acc <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (sample_now) begin
                        cnt            <= '0;
                        shreg[bit_cnt] <= bit_val;
                        par_acc        <= par_acc ^ bit_val;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == (cfg_seven ? 3'd6 : 3'd7)) begin
                            bit_cnt <= '0;
                            par_err <= 1'b0;
                            state   <= cfg_par ? S_PARITY : S_STOP;
                        end
                    end
                end

                S_PARITY: begin
                    if (sample_now) begin
                        cnt     <= '0;
                        par_err <= (par_acc ^ bit_val) != cfg_odd;
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (sample_now) begin
                        cnt <= '0;
                        if (!bit_val) begin
                            // Framing error: drop the character and wait for the line to go high.
                            oRETRY <= 1'b1;
                            state  <= S_WAIT_IDLE;
                        end else if (!cfg_two || bit_cnt == 3'd1) begin
                            oDE           <= 1'b1;
                            oDATA         <= DATA_WIDTH'(shreg);
                            oPARITY_ERROR <= cfg_par & par_err;
                            state         <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    // A held-low (break) line stays here, so it raises only one retry.
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core_m.sv
// Testbench for uart_rx_core_m.
//
// Clock and reset are generated here. Driver tasks serialize frames.
// A reference model predicts the delivered characters and retry pulses.
// A scoreboard compares the predictions against what the DUT strobes out.
module tb_uart_rx_core_m;

    localparam int OS = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT = 80;
`else
    localparam int LAT = 79;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seven = 1'b0;
    logic       par_en = 1'b0;
    logic       odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       rx = 1'b1;
    logic       ret;
    logic       perr;
    logic       de;
    logic [7:0] data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int retry_cnt = 0;
    int orphan_perr = 0;
    int last_de_cyc = 0;
    int start_cyc = 0;
    int exp_retry = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    uart_rx_core_m #(
        .OVER_SAMPLING(OS),
        .DATA_WIDTH(8)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .iSEVEN_BIT(seven),
        .iPARITY_EN(par_en),
        .iODD_PARITY(odd),
        .iSTOP_BIT(two_stop),
        .iUART_RX(rx),
        .oRETRY(ret),
        .oPARITY_ERROR(perr),
        .oDE(de),
        .oDATA(data)
    );

    // ---------------- clock and reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (de) begin
            obs_q.push_back({perr, data});
            last_de_cyc <= cyc;
        end
        if (ret) retry_cnt <= retry_cnt + 1;
        if (perr && !de) orphan_perr <= orphan_perr + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [8:0] g;
        logic [8:0] w;
        repeat (2 * OS) @(negedge clk);
        check({tag, " count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            g = obs_q.pop_front();
            w = exp_q.pop_front();
            check({tag, " data"}, {24'd0, g[7:0]}, {24'd0, w[7:0]});
            check({tag, " perr"}, {31'd0, g[8]}, {31'd0, w[8]});
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, " retry"}, retry_cnt, exp_retry);
        check({tag, " orphan_perr"}, orphan_perr, 0);
    endtask

    // ---------------- drivers ----------------
    // Each bit is held for OS clocks. Tasks are entered and left on a negedge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (OS) @(negedge clk);
    endtask

    // Reference model and driver for one frame.
    // flip_par sends the wrong parity bit.
    // stop_pat[i] is the level driven for stop bit i.
    task automatic send_frame(input logic [7:0] d, input logic s7, input logic pen,
                              input logic podd, input logic ts, input logic flip_par,
                              input logic [1:0] stop_pat);
        logic [7:0] m;
        logic       pbit;
        m = s7 ? {1'b0, d[6:0]} : d;
        pbit = (^m) ^ podd ^ flip_par;
        if (stop_pat[0] && (!ts || stop_pat[1]))
            exp_q.push_back({pen & flip_par, m});
        else
            exp_retry++;
        seven = s7;
        par_en = pen;
        odd = podd;
        two_stop = ts;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < (s7 ? 7 : 8); i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop_pat[0]);
        if (ts) drive_bit(stop_pat[1]);
        rx = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] msg[5];
        logic [7:0] d;
        logic       s7;
        logic       pen;
        logic       podd;
        logic       ts;
        logic       flip;
        logic [1:0] sp;
        int         gap;

        msg[0] = 8'h73;
        msg[1] = 8'h74;
        msg[2] = 8'h6F;
        msg[3] = 8'h70;
        msg[4] = 8'h0A;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset oDE", {31'd0, de}, 0);
        check("reset oRETRY", {31'd0, ret}, 0);
        check("reset oPARITY_ERROR", {31'd0, perr}, 0);
        check("reset oDATA", {24'd0, data}, 0);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);

        // 8N1 0x55, including the start-to-strobe latency.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        compare_all("8N1 55");
        check("8N1 latency", last_de_cyc - start_cyc, LAT);

        // 7N1 back-to-back "stop\n".
        for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        compare_all("7N1 stream");

        // 8E1 0xA3 with wrong then correct parity.
        send_frame(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
        compare_all("8E1 bad parity");
        send_frame(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        compare_all("8E1 good parity");

        // Two-clock low glitch on an idle line.
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        exp_retry++;
        repeat (2 * OS) @(negedge clk);
        compare_all("glitch");

        // 8N2 with a bad second stop bit, followed by a break.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (2 * OS) @(negedge clk);
        compare_all("8N2 framing+break");
        check("framing hold oDATA", {24'd0, data}, 32'hA3);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
        compare_all("8N2 81");

        // Reset in the middle of data bit 4.
        seven = 1'b0;
        par_en = 1'b0;
        two_stop = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midframe rst oDATA", {24'd0, data}, 0);
        check("midframe rst oDE", {31'd0, de}, 0);
        check("midframe rst oRETRY", {31'd0, ret}, 0);
        check("midframe rst oPARITY_ERROR", {31'd0, perr}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        compare_all("after rst 12");

        // Random formats, data, parity faults and framing faults.
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom_range(0, 255));
            s7 = 1'($urandom_range(0, 1));
            pen = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            flip = pen && ($urandom_range(0, 3) == 0);
            sp = 2'b11;
            gap = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
                sp = ts ? ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01) : 2'b10;
                gap = gap + 1;
            end
            send_frame(d, s7, pen, podd, ts, flip, sp);
            repeat (gap * OS) @(negedge clk);
        end
        compare_all("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
